com_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single `uart_32bit_tx` transmitter among up to 16 on-chip requesters, such as the CPU bridge, a PC/trace reporter and a debug status port. Each granted transfer is framed as an optional one-byte source header followed by a 1-byte or 4-byte payload. The block sits between the requesters and the transmitter, sequences the transmitter's start/done handshake, and returns a one-cycle completion pulse to the winning requester.

---
 rtl/com_pkg.sv | 7 +
 rtl/com_tx_arbiter_rr_pick.sv | 27 ++
 rtl/com_tx_arbiter.sv | 111 +++++++++++
 tb/tb_com_tx_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// Shared types and constants for the comms transmit path.
package com_pkg;
  localparam int         MAX_REQ   = 16;
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [2:0] {IDLE, HDR, GAP, PAYLOAD, ACK} arb_state_t;
endpackage

// File: rtl/com_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_idx, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      last_idx,
  output logic            valid,
  output logic [3:0]      idx
);
  always_comb begin
    int best;
    int d;
    best  = NREQ;
    d     = 0;
    idx   = '0;
    valid = |req;
    // Rotated distance from last_idx; smallest distance wins.
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(last_idx) - 1;
      if (d < 0) d = d + NREQ;
      if (req[i] && d < best) begin
        best = d;
        idx  = 4'(i);
      end
    end
  end
endmodule

// File: rtl/com_tx_arbiter.sv
// Round-robin arbiter sharing one uart_32bit_tx among NREQ sources,
// framing each grant as optional header byte + 1- or 4-byte payload.
module com_tx_arbiter
  import com_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int HEADER_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [32*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_one_byte,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [3:0]        grant_idx,
  output logic              tx_start,
  output logic [31:0]       tx_data,
  output logic              tx_one_byte,
  input  logic              tx_done
);
  arb_state_t  state, state_nxt;
  logic [3:0]  last_idx, pick_idx, idx_n;
  logic        pick_valid, pick_ob, grant;
  logic [31:0] pick_data, lat_data, data_n;
  logic        lat_one_byte, ob_n;
  logic        tx_start_n, tx_one_byte_n;
  logic [31:0] tx_data_n;
  logic [NREQ-1:0] done_n;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (req),
    .last_idx (last_idx),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    pick_ob   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == 4'(i)) begin
        pick_data = req_data[32*i +: 32];
        pick_ob   = req_one_byte[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE:    if (pick_valid) begin
                 grant     = 1'b1;
                 state_nxt = (HEADER_EN != 0) ? HDR : PAYLOAD;
               end
      HDR:     if (tx_done) state_nxt = GAP;
      GAP:     state_nxt = PAYLOAD;
      PAYLOAD: if (tx_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    idx_n         = grant ? pick_idx  : grant_idx;
    data_n        = grant ? pick_data : lat_data;
    ob_n          = grant ? pick_ob   : lat_one_byte;
    tx_start_n    = (state_nxt == HDR) || (state_nxt == PAYLOAD);
    tx_data_n     = tx_data;
    tx_one_byte_n = tx_one_byte;
    if (state_nxt == HDR) begin
      tx_data_n     = {24'h0, HDR_MAGIC, idx_n};
      tx_one_byte_n = 1'b1;
    end else if (state_nxt == PAYLOAD) begin
      tx_data_n     = ob_n ? {24'h0, data_n[7:0]} : data_n;
      tx_one_byte_n = ob_n;
    end
    for (int i = 0; i < NREQ; i++)
      done_n[i] = (state_nxt == ACK) && (idx_n == 4'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_idx     <= 4'(NREQ-1);
      grant_idx    <= '0;
      lat_data     <= '0;
      lat_one_byte <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      tx_one_byte  <= 1'b0;
      done         <= '0;
      busy         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        grant_idx    <= pick_idx;
        lat_data     <= pick_data;
        lat_one_byte <= pick_ob;
      end
      if (state == ACK) last_idx <= grant_idx;
      tx_start    <= tx_start_n;
      tx_data     <= tx_data_n;
      tx_one_byte <= tx_one_byte_n;
      done        <= done_n;
      busy        <= (state_nxt != IDLE);
    end
  end
endmodule

// File: tb/tb_com_tx_arbiter.sv
// Directed bench for com_tx_arbiter: header and header-less instances.
module tb_com_tx_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req = '0, req_one_byte = '0, done;
  logic [32*NREQ-1:0] req_data;
  logic               busy, tx_start, tx_one_byte;
  logic               tx_done = 1'b0;
  logic [3:0]         grant_idx;
  logic [31:0]        tx_data;

  logic [NREQ-1:0]    req0 = '0, req_one_byte0 = '0, done0;
  logic [32*NREQ-1:0] req_data0 = '0;
  logic               busy0, tx_start0, tx_one_byte0;
  logic               tx_done0 = 1'b0;
  logic [3:0]         grant_idx0;
  logic [31:0]        tx_data0;

  com_tx_arbiter #(.NREQ(NREQ), .HEADER_EN(1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_one_byte(req_one_byte), .done(done), .busy(busy),
    .grant_idx(grant_idx), .tx_start(tx_start), .tx_data(tx_data),
    .tx_one_byte(tx_one_byte), .tx_done(tx_done)
  );

  com_tx_arbiter #(.NREQ(NREQ), .HEADER_EN(0)) dut_nh (
    .clk(clk), .reset(reset), .req(req0), .req_data(req_data0),
    .req_one_byte(req_one_byte0), .done(done0), .busy(busy0),
    .grant_idx(grant_idx0), .tx_start(tx_start0), .tx_data(tx_data0),
    .tx_one_byte(tx_one_byte0), .tx_done(tx_done0)
  );

  // Transmitter models: tx_done pulses 3 cycles after tx_start rises.
  logic       prev_a = 1'b0, prev_b = 1'b0;
  logic [1:0] cnt_a = '0, cnt_b = '0;
  always @(posedge clk) begin
    if (reset) begin
      prev_a <= 1'b0; cnt_a <= '0; tx_done <= 1'b0;
    end else begin
      prev_a  <= tx_start;
      tx_done <= 1'b0;
      if (tx_start && !prev_a) cnt_a <= 2'd2;
      else if (cnt_a != 0) begin
        cnt_a <= cnt_a - 2'd1;
        if (cnt_a == 2'd1) tx_done <= 1'b1;
      end
    end
  end
  always @(posedge clk) begin
    if (reset) begin
      prev_b <= 1'b0; cnt_b <= '0; tx_done0 <= 1'b0;
    end else begin
      prev_b   <= tx_start0;
      tx_done0 <= 1'b0;
      if (tx_start0 && !prev_b) cnt_b <= 2'd2;
      else if (cnt_b != 0) begin
        cnt_b <= cnt_b - 2'd1;
        if (cnt_b == 2'd1) tx_done0 <= 1'b1;
      end
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  ob;
    logic [3:0]  idx;
    logic [31:0] payload;
    logic        pob;
  } vec_t;
  vec_t vecs [10];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; req_one_byte = '0; req0 = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_tx_ob", 32'(tx_one_byte), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    reset = 1'b0;
  endtask

  // One framed transfer on the header instance; next request levels applied
  // in the cycle done is seen, so IDLE arbitrates on them immediately.
  task automatic run_xfer(input vec_t v, input logic [3:0] nreq, input logic [3:0] nob);
    int n;
    logic [31:0] keep;
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("hdr_start", 32'(tx_start), 32'd1);
    chk("hdr_word", tx_data, {24'h0, 4'hA, v.idx});
    chk("hdr_ob", 32'(tx_one_byte), 32'd1);
    chk("grant_idx", 32'(grant_idx), 32'(v.idx));
    keep = req_data[32*v.idx +: 32];
    req_data[32*v.idx +: 32] = ~keep;
    n = 0;
    while (tx_start === 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("hdr_len", 32'(n), 32'd4);
    chk("gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("pay_start", 32'(tx_start), 32'd1);
    chk("pay_word", tx_data, v.payload);
    chk("pay_ob", 32'(tx_one_byte), 32'(v.pob));
    n = 0;
    while (tx_start === 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("pay_len", 32'(n), 32'd4);
    chk("done_hot", 32'(done), 32'(4'b0001 << v.idx));
    req_data[32*v.idx +: 32] = keep;
    req = nreq; req_one_byte = nob;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    if (nreq == 4'd0) chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    req = vecs[lo].req; req_one_byte = vecs[lo].ob;
    for (int r = lo; r <= hi; r++) begin
      if (r < hi) run_xfer(vecs[r], vecs[r+1].req, vecs[r+1].ob);
      else        run_xfer(vecs[r], 4'd0, 4'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    req_data = {32'h12345678, 32'h0BADF00D, 32'hDEADBEEF, 32'hA5A50000};
    vecs[0] = '{req:4'h2, ob:4'h0, idx:4'd1, payload:32'hDEADBEEF, pob:1'b0};
    vecs[1] = '{req:4'h5, ob:4'h0, idx:4'd0, payload:32'hA5A50000, pob:1'b0};
    vecs[2] = '{req:4'h4, ob:4'h0, idx:4'd2, payload:32'h0BADF00D, pob:1'b0};
    vecs[3] = '{req:4'hF, ob:4'h0, idx:4'd0, payload:32'hA5A50000, pob:1'b0};
    vecs[4] = '{req:4'hF, ob:4'h0, idx:4'd1, payload:32'hDEADBEEF, pob:1'b0};
    vecs[5] = '{req:4'hF, ob:4'h0, idx:4'd2, payload:32'h0BADF00D, pob:1'b0};
    vecs[6] = '{req:4'hF, ob:4'h0, idx:4'd3, payload:32'h12345678, pob:1'b0};
    vecs[7] = '{req:4'hF, ob:4'h0, idx:4'd0, payload:32'hA5A50000, pob:1'b0};
    vecs[8] = '{req:4'hF, ob:4'h0, idx:4'd1, payload:32'hDEADBEEF, pob:1'b0};
    vecs[9] = '{req:4'h8, ob:4'h8, idx:4'd3, payload:32'h00000078, pob:1'b1};

    do_reset();
    run_rows(0, 0);
    do_reset();
    run_rows(1, 2);
    do_reset();
    run_rows(3, 9);

    // Reset during PAYLOAD: everything clears, source 0 wins afterwards.
    do_reset();
    req = 4'b0010;
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (tx_start === 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("mid_pay_start", 32'(tx_start), 32'd1);
    reset = 1'b1; req = 4'b0011;
    @(negedge clk);
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_data", tx_data, 32'd0);
    reset = 1'b0;
    run_xfer(vecs[1], 4'b0010, 4'd0);
    run_xfer(vecs[0], 4'd0, 4'd0);

    // Header-less instance: payload starts the cycle after the request.
    @(negedge clk);
    req_data0[64 +: 32] = 32'hCAFEF00D;
    req0 = 4'b0100;
    @(negedge clk);
    chk("nh_start", 32'(tx_start0), 32'd1);
    chk("nh_word", tx_data0, 32'hCAFEF00D);
    chk("nh_ob", 32'(tx_one_byte0), 32'd0);
    chk("nh_grant", 32'(grant_idx0), 32'd2);
    n = 0;
    while (tx_done0 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("nh_txdone_lat", 32'(n), 32'd3);
    chk("nh_done_early", 32'(done0), 32'd0);
    @(negedge clk);
    chk("nh_done", 32'(done0), 32'b0100);
    chk("nh_ack_start", 32'(tx_start0), 32'd0);
    req0 = '0;
    @(negedge clk);
    chk("nh_done_pulse", 32'(done0), 32'd0);
    chk("nh_idle_busy", 32'(busy0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
